// File: rtl/microsequencer.sv
// LC-3 microprogram sequencer: drives the registered-output control store and
// computes each next microaddress from IRD/COND/J plus BEN, R and IR.
module microsequencer #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned WORD_W     = 52,
  parameter int unsigned NUM_STATES = 64,
  parameter int unsigned RESET_ADDR = 18,
  parameter int unsigned IRD_BIT    = 51,
  parameter int unsigned COND_LSB   = 49,
  parameter int unsigned J_LSB      = 43,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_halt,
  input  logic              i_ben,
  input  logic              i_r,
  input  logic [15:0]       i_ir,
  input  logic [WORD_W-1:0] i_cs_word,
  output logic              o_cs_read_en,
  output logic [ADDR_W-1:0] o_cs_read_addr,
  output logic              o_word_valid,
  output logic [ADDR_W-1:0] o_upc,
  output logic              o_halted,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_ucount
);

  typedef enum logic [1:0] {StBoot, StExec, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  ucount_q, ucount_d;

  logic              ird;
  logic [1:0]        cond;
  logic [ADDR_W-1:0] j_field;
  logic [ADDR_W-1:0] nxt;
  logic              illegal;

  // Only the sequencing fields and IR[15:11] matter here; the rest feeds the datapath.
  logic unused_bits;
  assign unused_bits = ^{i_cs_word, i_ir};

  assign ird     = i_cs_word[IRD_BIT];
  assign cond    = i_cs_word[COND_LSB +: 2];
  assign j_field = i_cs_word[J_LSB +: ADDR_W];

  always_comb begin
    nxt = j_field;
    if (ird) begin
      nxt = ADDR_W'(i_ir[15:12]);
    end else begin
      nxt[2] = j_field[2] | ((cond == 2'b10) & i_ben);
      nxt[1] = j_field[1] | ((cond == 2'b01) & i_r);
      nxt[0] = j_field[0] | ((cond == 2'b11) & i_ir[11]);
    end
  end

  assign illegal = (32'(nxt) >= NUM_STATES);

  always_comb begin
    state_d        = state_q;
    upc_d          = upc_q;
    pend_addr_d    = pend_addr_q;
    err_d          = err_q;
    ucount_d       = ucount_q;
    o_cs_read_en   = 1'b0;
    o_cs_read_addr = '0;
    o_word_valid   = 1'b0;
    o_halted       = 1'b0;
    // Reset is applied by the register block; outputs stay quiet while it is held.
    if (!i_RST) begin
      unique case (state_q)
        StBoot: begin
          o_cs_read_en   = 1'b1;
          o_cs_read_addr = pend_addr_q;
          upc_d          = pend_addr_q;
          state_d        = StExec;
        end
        StExec: begin
          o_word_valid = 1'b1;
          ucount_d     = ucount_q + CNT_W'(1);
          if (illegal) begin
            err_d       = 1'b1;
            pend_addr_d = nxt;
            state_d     = StHalt;
          end else if (i_halt) begin
            pend_addr_d = nxt;
            state_d     = StHalt;
          end else begin
            o_cs_read_en   = 1'b1;
            o_cs_read_addr = nxt;
            upc_d          = nxt;
          end
        end
        StHalt: begin
          o_halted = 1'b1;
          // An error is terminal until reset; resume re-fetches via BOOT.
          if (!err_q && !i_halt) begin
            state_d = StBoot;
          end
        end
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= StBoot;
      upc_q       <= ADDR_W'(RESET_ADDR);
      pend_addr_q <= ADDR_W'(RESET_ADDR);
      err_q       <= 1'b0;
      ucount_q    <= '0;
    end else begin
      state_q     <= state_d;
      upc_q       <= upc_d;
      pend_addr_q <= pend_addr_d;
      err_q       <= err_d;
      ucount_q    <= ucount_d;
    end
  end

  assign o_upc    = upc_q;
  assign o_err    = err_q;
  assign o_ucount = ucount_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: vector table for next-address decode plus
// hand-written halt/resume, illegal-address and reset sequences.
module tb_microsequencer;

  logic        i_CLK;
  logic        i_RST;
  logic        i_halt;
  logic        i_ben;
  logic        i_r;
  logic [15:0] i_ir;
  logic [51:0] i_cs_word;
  logic        o_cs_read_en;
  logic [5:0]  o_cs_read_addr;
  logic        o_word_valid;
  logic [5:0]  o_upc;
  logic        o_halted;
  logic        o_err;
  logic [31:0] o_ucount;

  microsequencer #(
    .NUM_STATES(50)
  ) dut (
    .i_CLK          (i_CLK),
    .i_RST          (i_RST),
    .i_halt         (i_halt),
    .i_ben          (i_ben),
    .i_r            (i_r),
    .i_ir           (i_ir),
    .i_cs_word      (i_cs_word),
    .o_cs_read_en   (o_cs_read_en),
    .o_cs_read_addr (o_cs_read_addr),
    .o_word_valid   (o_word_valid),
    .o_upc          (o_upc),
    .o_halted       (o_halted),
    .o_err          (o_err),
    .o_ucount       (o_ucount)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic        ird;
    logic [1:0]  cond;
    logic [5:0]  j;
    logic        ben;
    logic        r;
    logic [15:0] ir;
    logic [5:0]  exp_addr;
  } vec_t;

  localparam int NumVecs = 14;
  vec_t vecs[NumVecs];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  logic [5:0] exp_upc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [51:0] mk(input logic ird, input logic [1:0] cond,
                                     input logic [5:0] j);
    return {ird, cond, j, {43{1'b1}}};
  endfunction

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  // Ticks out of an EXEC cycle, which retires one microinstruction.
  task automatic tick_exec();
    exp_cnt++;
    tick();
  endtask

  initial begin
    // NUM_STATES is 50 in this instance, so 49 is the last legal address.
    vecs[0]  = '{1'b1, 2'b00, 6'd0,  1'b0, 1'b0, 16'h1042, 6'd1};
    vecs[1]  = '{1'b1, 2'b10, 6'd63, 1'b1, 1'b1, 16'hF025, 6'd15};
    vecs[2]  = '{1'b0, 2'b01, 6'd33, 1'b0, 1'b0, 16'h0000, 6'd33};
    vecs[3]  = '{1'b0, 2'b01, 6'd33, 1'b0, 1'b0, 16'h0000, 6'd33};
    vecs[4]  = '{1'b0, 2'b01, 6'd33, 1'b0, 1'b0, 16'h0000, 6'd33};
    vecs[5]  = '{1'b0, 2'b01, 6'd33, 1'b0, 1'b1, 16'h0000, 6'd35};
    vecs[6]  = '{1'b0, 2'b10, 6'd18, 1'b1, 1'b0, 16'h0000, 6'd22};
    vecs[7]  = '{1'b0, 2'b10, 6'd18, 1'b0, 1'b1, 16'h0800, 6'd18};
    vecs[8]  = '{1'b0, 2'b11, 6'd20, 1'b0, 1'b0, 16'h0800, 6'd21};
    vecs[9]  = '{1'b0, 2'b11, 6'd20, 1'b1, 1'b1, 16'hF7FF, 6'd20};
    vecs[10] = '{1'b0, 2'b01, 6'd33, 1'b1, 1'b0, 16'h0800, 6'd33};
    vecs[11] = '{1'b0, 2'b00, 6'd40, 1'b1, 1'b1, 16'hFFFF, 6'd40};
    vecs[12] = '{1'b0, 2'b00, 6'd49, 1'b0, 1'b0, 16'h0000, 6'd49};
    vecs[13] = '{1'b0, 2'b10, 6'd18, 1'b0, 1'b0, 16'h0000, 6'd18};

    i_RST     = 1'b1;
    i_halt    = 1'b0;
    i_ben     = 1'b0;
    i_r       = 1'b0;
    i_ir      = 16'h0000;
    i_cs_word = '0;
    tick();
    tick();
    check("rst read_en", 64'(o_cs_read_en), 64'd0);
    check("rst valid",   64'(o_word_valid), 64'd0);
    check("rst halted",  64'(o_halted), 64'd0);
    check("rst err",     64'(o_err), 64'd0);
    check("rst ucount",  64'(o_ucount), 64'd0);
    check("rst upc",     64'(o_upc), 64'd18);

    // BOOT ignores halt.
    i_RST  = 1'b0;
    i_halt = 1'b1;
    #1;
    check("boot read_en", 64'(o_cs_read_en), 64'd1);
    check("boot addr",    64'(o_cs_read_addr), 64'd18);
    check("boot valid",   64'(o_word_valid), 64'd0);
    check("boot halted",  64'(o_halted), 64'd0);
    tick();
    i_halt  = 1'b0;
    exp_upc = 6'd18;

    for (int i = 0; i < NumVecs; i++) begin
      i_cs_word = mk(vecs[i].ird, vecs[i].cond, vecs[i].j);
      i_ben     = vecs[i].ben;
      i_r       = vecs[i].r;
      i_ir      = vecs[i].ir;
      #1;
      check($sformatf("vec%0d valid", i),   64'(o_word_valid), 64'd1);
      check($sformatf("vec%0d read_en", i), 64'(o_cs_read_en), 64'd1);
      check($sformatf("vec%0d addr", i),    64'(o_cs_read_addr), 64'(vecs[i].exp_addr));
      check($sformatf("vec%0d upc", i),     64'(o_upc), 64'(exp_upc));
      check($sformatf("vec%0d ucount", i),  64'(o_ucount), 64'(exp_cnt));
      check($sformatf("vec%0d halted", i),  64'(o_halted), 64'd0);
      exp_upc = vecs[i].exp_addr;
      tick_exec();
    end

    // Halt at upc=18 with nxt=33: current word still executes, no store read.
    i_cs_word = mk(1'b0, 2'b00, 6'd33);
    i_ben     = 1'b0;
    i_r       = 1'b0;
    i_ir      = 16'h0000;
    i_halt    = 1'b1;
    #1;
    check("halt req upc",     64'(o_upc), 64'd18);
    check("halt req valid",   64'(o_word_valid), 64'd1);
    check("halt req read_en", 64'(o_cs_read_en), 64'd0);
    check("halt req addr",    64'(o_cs_read_addr), 64'd0);
    tick_exec();
    check("halted flag",     64'(o_halted), 64'd1);
    check("halted read_en",  64'(o_cs_read_en), 64'd0);
    check("halted addr",     64'(o_cs_read_addr), 64'd0);
    check("halted valid",    64'(o_word_valid), 64'd0);
    check("halted ucount",   64'(o_ucount), 64'(exp_cnt));
    tick();
    check("halted hold",     64'(o_halted), 64'd1);
    check("halted ucount2",  64'(o_ucount), 64'(exp_cnt));
    i_halt = 1'b0;
    #1;
    check("resume cyc0 halted",  64'(o_halted), 64'd1);
    check("resume cyc0 read_en", 64'(o_cs_read_en), 64'd0);
    tick();
    check("resume boot read_en", 64'(o_cs_read_en), 64'd1);
    check("resume boot addr",    64'(o_cs_read_addr), 64'd33);
    check("resume boot halted",  64'(o_halted), 64'd0);
    check("resume boot valid",   64'(o_word_valid), 64'd0);
    tick();
    i_cs_word = mk(1'b0, 2'b00, 6'd12);
    #1;
    check("resume exec valid", 64'(o_word_valid), 64'd1);
    check("resume exec upc",   64'(o_upc), 64'd33);
    check("resume exec addr",  64'(o_cs_read_addr), 64'd12);
    tick_exec();

    // First illegal address at the exact boundary (50 with NUM_STATES=50).
    i_cs_word = mk(1'b0, 2'b00, 6'd50);
    #1;
    check("ill50 read_en", 64'(o_cs_read_en), 64'd0);
    check("ill50 addr",    64'(o_cs_read_addr), 64'd0);
    check("ill50 valid",   64'(o_word_valid), 64'd1);
    check("ill50 err pre", 64'(o_err), 64'd0);
    tick_exec();
    check("ill50 err",     64'(o_err), 64'd1);
    check("ill50 halted",  64'(o_halted), 64'd1);
    check("ill50 read_en2", 64'(o_cs_read_en), 64'd0);
    for (int k = 0; k < 4; k++) begin
      i_halt = (k % 2 == 0);
      tick();
      check($sformatf("ill50 stuck%0d halted", k), 64'(o_halted), 64'd1);
      check($sformatf("ill50 stuck%0d err", k),    64'(o_err), 64'd1);
      check($sformatf("ill50 stuck%0d read_en", k), 64'(o_cs_read_en), 64'd0);
      check($sformatf("ill50 stuck%0d ucount", k), 64'(o_ucount), 64'(exp_cnt));
    end
    i_halt = 1'b0;

    i_RST = 1'b1;
    tick();
    exp_cnt = 0;
    check("rerst err",     64'(o_err), 64'd0);
    check("rerst halted",  64'(o_halted), 64'd0);
    check("rerst read_en", 64'(o_cs_read_en), 64'd0);
    check("rerst ucount",  64'(o_ucount), 64'd0);
    check("rerst upc",     64'(o_upc), 64'd18);
    i_RST = 1'b0;
    #1;
    check("reboot read_en", 64'(o_cs_read_en), 64'd1);
    check("reboot addr",    64'(o_cs_read_addr), 64'd18);
    tick();

    // J=48 with BEN branch gives 52; illegal wins over a concurrent halt request.
    i_cs_word = mk(1'b0, 2'b10, 6'd48);
    i_ben     = 1'b1;
    i_halt    = 1'b1;
    #1;
    check("ill52 upc",     64'(o_upc), 64'd18);
    check("ill52 read_en", 64'(o_cs_read_en), 64'd0);
    check("ill52 valid",   64'(o_word_valid), 64'd1);
    tick_exec();
    i_halt = 1'b0;
    tick();
    tick();
    check("ill52 err",     64'(o_err), 64'd1);
    check("ill52 halted",  64'(o_halted), 64'd1);
    check("ill52 read_en", 64'(o_cs_read_en), 64'd0);
    check("ill52 valid",   64'(o_word_valid), 64'd0);
    check("ill52 ucount",  64'(o_ucount), 64'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
